// File: rtl/i2c_burst_writer.sv
// i2c_burst_writer: I2C master that writes address, register and data bytes in one burst, or waits a fixed delay
module i2c_burst_writer #(
    parameter int CLK_DIV      = 125,
    parameter int ADDR_BYTES   = 1,
    parameter int DATA_BYTES   = 1,
    parameter int DELAY_CYCLES = 10000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    START,
    input  logic                    DELAY_REQ,
    input  logic [6:0]              SL_ADDR,
    input  logic [8*ADDR_BYTES-1:0] REG_ADDR,
    input  logic [8*DATA_BYTES-1:0] REG_DATA,
    input  logic                    SDAI,
    output logic                    SCL,
    output logic                    SDA,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    NACK
);
    localparam int N  = 1 + ADDR_BYTES + DATA_BYTES;
    localparam int FW = 8 * N;
    localparam int QW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int DW = DELAY_CYCLES > 1 ? $clog2(DELAY_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE, DELAY, START_A, START_B, BIT_Q0, BIT_Q1, BIT_Q2, BIT_Q3,
        STOP_A, STOP_B, STOP_C, FIN
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [FW-1:0]   sh_q, sh_d;
    logic            nack_q, nack_d;
    logic            sda_q;
    logic            tick, dbit, last_byte, bus;

    assign tick      = qcnt_q == QW'(CLK_DIV - 1);
    assign last_byte = byte_q == 3'(N - 1);
    assign dbit      = bit_q == 4'd8 ? 1'b1 : sh_q[FW-1];
    assign bus       = state_q != IDLE && state_q != DELAY && state_q != FIN;
    assign NACK      = nack_q;

    // State, counters and shift register; sda_q remembers the last driven SDA so Q0 can hold it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            dcnt_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            nack_q  <= 1'b0;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            dcnt_q  <= dcnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            nack_q  <= nack_d;
            sda_q   <= SDA;
        end
    end

    // Next-state logic and bus levels; every bus state lasts one quarter tick
    always_comb begin
        state_d = state_q;
        qcnt_d  = bus ? (tick ? '0 : qcnt_q + 1'b1) : qcnt_q;
        dcnt_d  = dcnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        nack_d  = nack_q;
        SCL     = 1'b1;
        SDA     = 1'b1;
        BUSY    = state_q != IDLE && state_q != FIN;
        DONE    = state_q == FIN;
        case (state_q)
            IDLE: if (START) begin
                state_d = DELAY_REQ ? DELAY : START_A;
                qcnt_d  = '0;
                dcnt_d  = '0;
                bit_d   = '0;
                byte_d  = '0;
                sh_d    = {SL_ADDR, 1'b0, REG_ADDR, REG_DATA};
                nack_d  = 1'b0;
            end
            DELAY: begin
                dcnt_d  = dcnt_q + 1'b1;
                state_d = dcnt_q == DW'(DELAY_CYCLES - 1) ? FIN : DELAY;
            end
            START_A: state_d = tick ? START_B : START_A;
            START_B: begin
                SDA     = 1'b0;
                state_d = tick ? BIT_Q0 : START_B;
            end
            BIT_Q0: begin
                SCL     = 1'b0;
                SDA     = sda_q;
                state_d = tick ? BIT_Q1 : BIT_Q0;
            end
            BIT_Q1: begin
                SCL     = 1'b0;
                SDA     = dbit;
                state_d = tick ? BIT_Q2 : BIT_Q1;
            end
            BIT_Q2: begin
                SDA     = dbit;
                state_d = tick ? BIT_Q3 : BIT_Q2;
                nack_d  = nack_q | (tick && bit_q == 4'd8 && SDAI);
            end
            BIT_Q3: begin
                SDA = dbit;
                if (tick) begin
                    if (bit_q == 4'd8) begin
                        bit_d   = '0;
                        byte_d  = byte_q + 1'b1;
                        state_d = nack_q || last_byte ? STOP_A : BIT_Q0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sh_d    = sh_q << 1;
                        state_d = BIT_Q0;
                    end
                end
            end
            STOP_A: begin
                SCL     = 1'b0;
                SDA     = 1'b0;
                state_d = tick ? STOP_B : STOP_A;
            end
            STOP_B: begin
                SDA     = 1'b0;
                state_d = tick ? STOP_C : STOP_B;
            end
            STOP_C:  state_d = tick ? FIN : STOP_C;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_burst_writer.sv
// tb_i2c_burst_writer: randomized scoreboard bench with a bus-level monitor and a simple ACK/NACK slave
module tb_i2c_burst_writer;
    localparam int CD  = 4;
    localparam int AB  = 2;
    localparam int DB  = 2;
    localparam int DLY = 20;
    localparam int NB  = 1 + AB + DB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic START = 1'b0;
    logic DELAY_REQ = 1'b0;
    logic [6:0] SL_ADDR = '0;
    logic [8*AB-1:0] REG_ADDR = '0;
    logic [8*DB-1:0] REG_DATA = '0;
    logic SDAI;
    logic SCL, SDA, BUSY, DONE, NACK;

    typedef struct {
        bit dly;
        bit nack;
        int nb;
        logic [8*NB-1:0] bytes;
        int cycles;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cur_nack_at = 0;
    bit mon_off = 1'b0;
    int rises, falls, starts, stops, busy_n, run, obs_n, kb;
    logic [8*NB-1:0] obs;
    logic prev_scl, prev_sda;
    int lows[$];
    int highs[$];

    i2c_burst_writer #(.CLK_DIV(CD), .ADDR_BYTES(AB), .DATA_BYTES(DB), .DELAY_CYCLES(DLY)) dut (
        .clk(clk), .reset(reset), .START(START), .DELAY_REQ(DELAY_REQ), .SL_ADDR(SL_ADDR),
        .REG_ADDR(REG_ADDR), .REG_DATA(REG_DATA), .SDAI(SDAI), .SCL(SCL), .SDA(SDA),
        .BUSY(BUSY), .DONE(DONE), .NACK(NACK)
    );

    always #5 clk = ~clk;

    // Slave: pulls SDA low in each ACK slot unless this is the byte chosen to be NACKed
    always_comb begin
        kb   = (rises + 1) / 9;
        SDAI = 1'b1;
        if ((rises % 9 == 8 && !SCL) || (rises % 9 == 0 && rises > 0 && SCL))
            SDAI = kb == cur_nack_at;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input bit dly, input logic [6:0] sl, input logic [8*AB-1:0] ra,
                                   input logic [8*DB-1:0] rd, input int nack_at);
        logic [7:0] bq[$];
        exp_t e;
        int m;
        bq.push_back({sl, 1'b0});
        for (int i = AB - 1; i >= 0; i--) bq.push_back(ra[8*i +: 8]);
        for (int i = DB - 1; i >= 0; i--) bq.push_back(rd[8*i +: 8]);
        e.nack   = !dly && nack_at >= 1 && nack_at <= NB;
        m        = e.nack ? nack_at : NB;
        e.dly    = dly;
        e.nb     = dly ? 0 : m;
        e.bytes  = '0;
        for (int i = 0; i < e.nb; i++) e.bytes = {e.bytes[8*NB-9:0], bq[i]};
        e.cycles = dly ? DLY : (5 + 36 * m) * CD;
        return e;
    endfunction

    task automatic mon_clear();
        rises = 0; falls = 0; starts = 0; stops = 0; busy_n = 0; run = 0; obs_n = 0;
        obs = '0; prev_scl = 1'b1; prev_sda = 1'b1;
        lows.delete(); highs.delete();
    endtask

    // Monitor: decodes the bus, measures SCL phases and BUSY length, and checks each DONE against the scoreboard
    initial begin
        exp_t e;
        int ok, m9;
        mon_clear();
        forever begin
            @(negedge clk);
            if (reset || mon_off) mon_clear();
            else begin
                if (BUSY) busy_n++;
                if (SCL && prev_scl && prev_sda && !SDA) starts++;
                if (SCL && prev_scl && !prev_sda && SDA) stops++;
                if (SCL != prev_scl) begin
                    if (SCL) begin
                        rises++;
                        lows.push_back(run);
                    end else begin
                        falls++;
                        highs.push_back(run);
                        if (falls >= 2 && (falls - 2) % 9 != 8) begin
                            obs = {obs[8*NB-2:0], prev_sda};
                            obs_n++;
                        end
                    end
                    run = 1;
                end else run++;
                prev_scl = SCL;
                prev_sda = SDA;
                if (DONE) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got DONE expected none");
                    end else begin
                        e = sb.pop_front();
                        chk("busy_cycles", busy_n, e.cycles);
                        chk("busy_low_at_done", BUSY, 0);
                        chk("nack_flag", NACK, e.nack);
                        chk("start_cond", starts, e.dly ? 0 : 1);
                        chk("stop_cond", stops, e.dly ? 0 : 1);
                        chk("bit_count", obs_n, 8 * e.nb);
                        chk("bytes", obs, e.bytes);
                        m9 = 9 * e.nb;
                        ok = 1;
                        if (lows.size() != (e.dly ? 0 : m9 + 1) || highs.size() != (e.dly ? 0 : m9 + 1)) ok = 0;
                        else if (!e.dly) begin
                            for (int i = 0; i < m9; i++) if (lows[i] != 2 * CD) ok = 0;
                            if (lows[m9] != CD) ok = 0;
                            for (int i = 1; i <= m9; i++) if (highs[i] != 2 * CD) ok = 0;
                        end
                        chk("scl_phases", ok, 1);
                    end
                    mon_clear();
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((BUSY || DONE) && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (BUSY || DONE) begin
            $display("FAIL idle_timeout: got busy expected idle");
            $fatal(1, "idle timeout");
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!DONE && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (!DONE) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE expected DONE");
        end
    endtask

    task automatic scramble();
        DELAY_REQ = 1'($urandom);
        SL_ADDR   = 7'($urandom);
        REG_ADDR  = (8*AB)'($urandom);
        REG_DATA  = (8*DB)'($urandom);
    endtask

    task automatic run_txn(input bit dly, input logic [6:0] sl, input logic [8*AB-1:0] ra,
                           input logic [8*DB-1:0] rd, input int nack_at, input bit poke);
        wait_idle();
        SL_ADDR = sl; REG_ADDR = ra; REG_DATA = rd; DELAY_REQ = dly; START = 1'b1;
        cur_nack_at = dly ? 0 : nack_at;
        sb.push_back(model(dly, sl, ra, rd, cur_nack_at));
        @(negedge clk);
        START = 1'b0;
        scramble();
        chk("busy_rise", BUSY, 1);
        chk("nack_clear_on_start", NACK, 0);
        if (poke) begin
            repeat ($urandom_range(1, 100)) @(negedge clk);
            START = 1'b1;
            @(negedge clk);
            START = 1'b0;
        end
        wait_done();
    endtask

    task automatic back_to_back();
        exp_t e;
        wait_idle();
        SL_ADDR = 7'h33; REG_ADDR = 16'hA55A; REG_DATA = 16'h0FF0; DELAY_REQ = 1'b0; START = 1'b1;
        cur_nack_at = 0;
        e = model(1'b0, 7'h33, 16'hA55A, 16'h0FF0, 0);
        sb.push_back(e);
        sb.push_back(e);
        @(negedge clk);
        chk("b2b_first_busy", BUSY, 1);
        wait_done();
        @(negedge clk);
        chk("b2b_idle_gap", BUSY, 0);
        @(negedge clk);
        chk("b2b_reaccept", BUSY, 1);
        START = 1'b0;
        wait_done();
    endtask

    task automatic reset_test();
        int t = 0;
        wait_idle();
        mon_off = 1'b1;
        cur_nack_at = 0;
        SL_ADDR = 7'h21; REG_ADDR = 16'h0A0A; REG_DATA = 16'h5C5C; DELAY_REQ = 1'b0; START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        repeat (6) @(negedge clk);
        START = 1'b1;
        DELAY_REQ = 1'b1;
        @(negedge clk);
        START = 1'b0;
        DELAY_REQ = 1'b0;
        chk("busy_ignores_start", BUSY, 1);
        while (!(SCL == 1'b0 && SDA == 1'b0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("mid_byte_scl_sda", {SCL, SDA}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_scl", SCL, 1);
        chk("rst_sda", SDA, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stays_idle", BUSY, 0);
        mon_off = 1'b0;
    endtask

    // Stimulus: directed cases from the plan, then randomized transactions
    initial begin
        repeat (3) @(negedge clk);
        chk("reset_scl", SCL, 1);
        chk("reset_sda", SDA, 1);
        chk("reset_busy", BUSY, 0);
        chk("reset_done", DONE, 0);
        chk("reset_nack", NACK, 0);
        reset = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 7'h21, 16'h3012, 16'hBEEF, 0, 1'b0);
        run_txn(1'b0, 7'h21, 16'h3012, 16'hBEEF, 2, 1'b0);
        run_txn(1'b1, 7'h11, 16'h1111, 16'h2222, 0, 1'b0);
        run_txn(1'b0, 7'h50, 16'h0A5C, 16'h1234, 0, 1'b1);
        run_txn(1'b0, 7'h7F, 16'hFFFF, 16'h0000, 1, 1'b0);
        run_txn(1'b0, 7'h00, 16'h8001, 16'h7E81, NB, 1'b1);
        back_to_back();
        reset_test();
        for (int i = 0; i < 20; i++) begin
            bit d;
            int na;
            d  = $urandom_range(0, 4) == 0;
            na = $urandom_range(0, 1) == 1 ? $urandom_range(1, NB) : 0;
            run_txn(d, 7'($urandom), (8*AB)'($urandom), (8*DB)'($urandom), d ? 0 : na, !d && $urandom_range(0, 1) == 1);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_burst_writer.md
# i2c_burst_writer

Parametrised I2C master write engine for the camera/sensor configuration path. It generates a full write transaction from one start request: START, 7-bit slave address + W, 1–2 register-address bytes, 1–4 data bytes, and STOP. It checks every ACK slot, aborts with STOP on NACK, and offers a timed-delay command so a configuration ROM sequencer can insert settle time. It sits between the configuration sequencer and the open-drain SCL/SDA pad logic.

## Interface
Parameters:
- CLK_DIV, 125: clk cycles per SCL quarter-period (≥1); 50 MHz / (4·125) = 100 kHz SCL.
- ADDR_BYTES, 1: register-address bytes (1 or 2).
- DATA_BYTES, 1: data bytes (1..4).
- DELAY_CYCLES, 10000: clk cycles waited by a delay command (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- START  in  1  request; accepted only when BUSY=0.
- DELAY_REQ  in  1  sampled with START; 1 = delay command, no bus activity.
- SL_ADDR  in  7  slave address.
- REG_ADDR  in  8·ADDR_BYTES  register address, MSB byte first on bus.
- REG_DATA  in  8·DATA_BYTES  write data, MSB byte first on bus.
- SDAI  in  1  SDA pad input.
- SCL  out  1  SCL level (1 = released/high).
- SDA  out  1  SDA level (1 = released/high; pad drives low only when 0).
- BUSY  out  1  transaction or delay in progress.
- DONE  out  1  one-cycle pulse at completion (success, NACK abort, or delay end).
- NACK  out  1  sticky; set on any NACK, cleared on next accepted START.

## Operation
- Reset values: SCL=1, SDA=1, BUSY=0, DONE=0, NACK=0, FSM in IDLE, counters 0.
- Acceptance: in IDLE with START=1, latch SL_ADDR/REG_ADDR/REG_DATA/DELAY_REQ. BUSY=1 from the next cycle. Input changes after acceptance are ignored. START while BUSY=1 is ignored.
- Quarter tick: the quarter counter runs 0..CLK_DIV-1 and ticks on CLK_DIV-1. Every bus state below lasts one quarter.
- FSM states: IDLE, DELAY, START_A, START_B, BIT_Q0..BIT_Q3, STOP_A, STOP_B, STOP_C, FIN.
- START_A: SCL=1, SDA=1. START_B: SCL=1, SDA=0.
- Per bit: Q0 SCL=0 (SDA unchanged); Q1 SCL=0, SDA=next bit; Q2 SCL=1; Q3 SCL=1.
- Bit order: 9 bits per byte, MSB first. The 9th bit is the ACK slot, with SDA=1 (released). SDAI is sampled on the tick that ends ACK-slot Q2: 0 = ACK, 1 = NACK.
- Byte sequence: {SL_ADDR, 1'b0}, then REG_ADDR bytes, then REG_DATA bytes. N = 1+ADDR_BYTES+DATA_BYTES bytes total, tracked by a byte counter.
- After the ACK slot: if NACK, or if the last byte has been sent, go to STOP_A; otherwise go to Q0 of the next byte. A NACK also sets NACK=1, and no further bytes are sent.
- Stop sequence: STOP_A SCL=0, SDA=0; STOP_B SCL=1, SDA=0; STOP_C SCL=1, SDA=1.
- FIN: DONE=1 for one cycle, BUSY=0 in the same cycle, then IDLE.
- DELAY: SCL and SDA stay 1. Wait DELAY_CYCLES clocks, then FIN.
- Reset mid-transaction: the next cycle SCL=1, SDA=1, and all state is reset. No STOP is generated; the sequencer is responsible for bus recovery.

## Timing
- Accept edge → BUSY=1: 1 cycle. The first bus change (SDA fall, START_B) comes CLK_DIV cycles after BUSY rises.
- Bus-state duration: 2 + 36·N + 3 quarters, i.e. (5+36N)·CLK_DIV cycles, counted from BUSY rise to FIN.
- Defaults (N=3, CLK_DIV=1): 113 cycles, then the DONE cycle.
- NACK on byte k (k=1..N): (2 + 36·k + 3)·CLK_DIV cycles, then DONE.
- Delay: BUSY high for DELAY_CYCLES cycles, then a one-cycle DONE.
- Back-to-back: START may be held high. It is re-accepted in the first IDLE cycle after the DONE cycle.
- SDA changes only while SCL=0, except in START_B and STOP_C.

## Test plan
- Default params, CLK_DIV=1, SL_ADDR=7'h21, REG_ADDR=8'h0A, REG_DATA=8'h5C, slave ACKs all → bits 0x42, 0x0A, 0x5C on SCL rising edges; DONE after 113 bus cycles; NACK=0.
- ADDR_BYTES=2, DATA_BYTES=2, REG_ADDR=16'h3012, REG_DATA=16'hBEEF → bytes 0x42, 0x30, 0x12, 0xBE, 0xEF; duration (5+180)·CLK_DIV cycles.
- Slave NACKs the 2nd byte (SDAI=1 in that ACK slot) → no 3rd byte, STOP follows, NACK=1, DONE after (5+72)·CLK_DIV cycles. The next START clears NACK.
- DELAY_REQ=1, DELAY_CYCLES=20 → BUSY high for 20 cycles, SCL and SDA constant 1, single DONE pulse.
- reset=1 mid-byte (SCL=0, SDA=0) → SCL=1, SDA=1, BUSY=0 the next cycle; START pulsed during BUSY is ignored.
- CLK_DIV=4: every SCL high and low phase lasts exactly 8 cycles; SDA is stable whenever SCL=1, except in START and STOP.
